// File: rtl/matrix_print_sequencer.sv
// Purpose: walks a rows x cols matrix in sync-read RAM row-major, emitting number/space/newline tokens.
// Latency: start accepted at edge k -> rd_en in cycle k+1 -> first token valid after edge k+2; 4 cycles/element.
// Backpressure: out_valid/out_ready; token held stable until accepted, no RAM read while a token is pending.
//
// Ports:
//    clk, rst_n               clock, synchronous active-low reset
//    start, rows, cols,       job request (sampled only when idle) and its dimensions/base address
//    base_addr
//    busy, done, error        status; error is meaningful only while done is high
//    rd_en, rd_addr, rd_data  RAM read port (data returns the cycle after rd_en)
//    out_data, out_type,      token stream: type 0 = number, 1 = space, 2 = newline
//    out_valid, out_ready
module matrix_print_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int DIM_WIDTH  = 3,
   parameter int MAX_DIM    = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIM_WIDTH-1:0]  rows,
   input  logic [DIM_WIDTH-1:0]  cols,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            out_type,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam logic [1:0] TYPE_NUM = 2'd0;
   localparam logic [1:0] TYPE_SP  = 2'd1;
   localparam logic [1:0] TYPE_NL  = 2'd2;

   typedef enum logic [2:0] {
      IDLE, READ, WAIT, EMIT_NUM, EMIT_SEP, FINISH
   } state_t;

   state_t                  state, state_nxt;
   logic [DIM_WIDTH-1:0]    rows_q, cols_q, r_q, c_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    err_q;
   logic [DATA_WIDTH-1:0]   out_data_q;
   logic [1:0]              out_type_q;
   logic                    out_valid_q;
   logic                    dims_bad, last_col, last_row;

   assign dims_bad = (rows == '0) || (cols == '0) ||
                     (int'(rows) > MAX_DIM) || (int'(cols) > MAX_DIM);
   // Dims are non-zero whenever these are used, so the decrement cannot underflow.
   assign last_col = (c_q == cols_q - DIM_WIDTH'(1));
   assign last_row = (r_q == rows_q - DIM_WIDTH'(1));

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = (state == FINISH);
      error     = (state == FINISH) && err_q;
      rd_en     = (state == READ);
      rd_addr   = addr_q;
      out_data  = out_data_q;
      out_type  = out_type_q;
      out_valid = out_valid_q;
      case (state)
         IDLE:     if (start) state_nxt = dims_bad ? FINISH : READ;
         READ:     state_nxt = WAIT;
         WAIT:     state_nxt = EMIT_NUM;
         EMIT_NUM: if (out_ready) state_nxt = EMIT_SEP;
         EMIT_SEP: begin
            if (out_ready)
               state_nxt = (out_type_q == TYPE_NL && last_row) ? FINISH : READ;
         end
         FINISH:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         rows_q      <= '0;
         cols_q      <= '0;
         r_q         <= '0;
         c_q         <= '0;
         addr_q      <= '0;
         err_q       <= 1'b0;
         out_data_q  <= '0;
         out_type_q  <= TYPE_NUM;
         out_valid_q <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  rows_q <= rows;
                  cols_q <= cols;
                  addr_q <= base_addr;
                  r_q    <= '0;
                  c_q    <= '0;
                  err_q  <= dims_bad;
               end
            end
            WAIT: begin
               // RAM data for the READ-cycle address is present now.
               out_data_q  <= rd_data;
               out_type_q  <= TYPE_NUM;
               out_valid_q <= 1'b1;
            end
            EMIT_NUM: begin
               if (out_ready) begin
                  out_data_q <= '0;
                  out_type_q <= last_col ? TYPE_NL : TYPE_SP;
               end
            end
            EMIT_SEP: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  // Row-major layout: next element is always the next address.
                  addr_q      <= addr_q + ADDR_WIDTH'(1);
                  if (out_type_q == TYPE_SP) begin
                     c_q <= c_q + DIM_WIDTH'(1);
                  end else if (!last_row) begin
                     r_q <= r_q + DIM_WIDTH'(1);
                     c_q <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_print_sequencer.sv
module tb_matrix_print_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  rows = '0;
   logic [2:0]  cols = '0;
   logic [5:0]  base_addr = '0;
   logic        busy, done, error, rd_en;
   logic [5:0]  rd_addr;
   logic [31:0] rd_data;
   logic [31:0] out_data;
   logic [1:0]  out_type;
   logic        out_valid;
   logic        out_ready = 1'b1;

   matrix_print_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rows(rows), .cols(cols),
      .base_addr(base_addr), .busy(busy), .done(done), .error(error),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_data(out_data), .out_type(out_type), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM model.
   logic [31:0] mem [0:63];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int total = 0;
   int bad = 0;
   int done_seen = 0;
   int ready_mode = 0;
   int bp_cnt = 0;
   logic [33:0] tq[$];
   logic [5:0]  aq[$];
   logic        dq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s", nm);
   endtask

   // Monitor / scoreboard.
   logic        pv = 1'b0, pr = 1'b0;
   logic [31:0] pd = '0;
   logic [1:0]  pt = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, pd);
            chk("stall_type", out_type, pt);
         end
         if (out_valid && out_ready) begin
            if (tq.size() == 0) fail_now($sformatf("unexpected_token type=%0d data=%0h", out_type, out_data));
            else chk("token", {out_type, out_data}, tq.pop_front());
         end
         if (rd_en) begin
            chk("rd_while_pending", out_valid, 0);
            if (aq.size() == 0) fail_now($sformatf("unexpected_read addr=%0d", rd_addr));
            else chk("rd_addr", rd_addr, aq.pop_front());
         end
         if (done) begin
            done_seen++;
            if (dq.size() == 0) fail_now("unexpected_done");
            else chk("done_error", error, dq.pop_front());
         end
         pv = out_valid;
         pr = out_ready;
         pd = out_data;
         pt = out_type;
      end
   end

   task automatic push_job(input int r, input int c, input logic [5:0] b);
      logic [5:0] a;
      if (r == 0 || c == 0) begin
         dq.push_back(1'b1);
      end else begin
         for (int i = 0; i < r * c; i++) begin
            a = b + 6'(i);
            aq.push_back(a);
            tq.push_back({2'd0, mem[a]});
            tq.push_back({((i % c) == c - 1) ? 2'd2 : 2'd1, 32'd0});
         end
         dq.push_back(1'b0);
      end
   endtask

   task automatic pulse(input logic [2:0] r, input logic [2:0] c, input logic [5:0] b);
      @(posedge clk); #1;
      start = 1'b1; rows = r; cols = c; base_addr = b;
      @(posedge clk); #1;
      start = 1'b0; rows = 3'd7; cols = 3'd5; base_addr = 6'd63;
   endtask

   task automatic wait_done(input int budget, input string nm);
      int s;
      s = done_seen;
      for (int i = 0; i < budget && done_seen == s; i++) begin
         @(negedge clk); #1;
      end
      chk(nm, done_seen != s, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_type"}, out_type, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i * 7);
      mem[0] = 32'h8000_0000;
      mem[4] = 32'd1;  mem[5] = -32'sd2; mem[6] = 32'd3;
      mem[7] = 32'd40; mem[8] = 32'd0;   mem[9] = -32'sd6;

      fork
         forever begin
            @(posedge clk); #1;
            case (ready_mode)
               1: begin out_ready = (bp_cnt >= 50) && (bp_cnt % 2 == 1); bp_cnt++; end
               2: out_ready = !(out_valid && out_type != 2'd0);
               default: out_ready = 1'b1;
            endcase
         end
      join_none

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // 2x3 matrix at base 4.
      push_job(2, 3, 6'd4);
      pulse(3'd2, 3'd3, 6'd4);
      wait_done(200, "done_2x3");

      // 1x1 matrix with most-negative value; first-token latency.
      push_job(1, 1, 6'd0);
      pulse(3'd1, 3'd1, 6'd0);
      @(negedge clk); chk("lat_rd_en_k1", rd_en, 1); chk("lat_valid_k1", out_valid, 0);
      @(negedge clk); chk("lat_valid_k2", out_valid, 0);
      @(negedge clk); chk("lat_valid_k3", out_valid, 1);
      wait_done(50, "done_1x1");

      // Backpressure on a 2x2 job whose addresses wrap past 63.
      bp_cnt = 0;
      ready_mode = 1;
      push_job(2, 2, 6'd62);
      pulse(3'd2, 3'd2, 6'd62);
      wait_done(500, "done_backpressure");
      ready_mode = 0;

      // Illegal dimensions.
      push_job(0, 3, 6'd8);
      pulse(3'd0, 3'd3, 6'd8);
      wait_done(2, "done_rows0");
      push_job(2, 0, 6'd8);
      pulse(3'd2, 3'd0, 6'd8);
      wait_done(2, "done_cols0");

      // start re-pulsed mid-job is ignored.
      push_job(2, 2, 6'd20);
      pulse(3'd2, 3'd2, 6'd20);
      repeat (5) @(posedge clk);
      pulse(3'd3, 3'd3, 6'd0);
      wait_done(200, "done_repulse");
      repeat (10) @(negedge clk);

      // Reset while stalled in EMIT_SEP of a 3x3 job.
      ready_mode = 2;
      aq.push_back(6'd30);
      tq.push_back({2'd0, mem[30]});
      pulse(3'd3, 3'd3, 6'd30);
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (out_valid && out_type != 2'd0) found = 1;
      end
      chk("sep_reached", found, 1);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk); #1;
      check_reset_outputs("midjob_reset");
      rst_n = 1'b1;
      ready_mode = 0;
      repeat (3) @(negedge clk);
      push_job(3, 3, 6'd30);
      pulse(3'd3, 3'd3, 6'd30);
      wait_done(300, "done_after_reset");

      repeat (5) @(negedge clk);
      chk("tokens_left", tq.size(), 0);
      chk("reads_left", aq.size(), 0);
      chk("dones_left", dq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
